imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/loader_timeout.sv | 45 ++++
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int INSN_WIDTH     = 16;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // Modulo-256 running checksum step.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the loader: counts enabled cycles since the last
// clear and flags once TIMEOUT cycles have elapsed.
module loader_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          expired_r;

  // Next count: saturates at TMAX so expired stays asserted until cleared.
  always_comb begin
    cnt_s = cnt_r;
    if (clr) begin
      cnt_s = '0;
    end else if (en && (cnt_r != TMAX)) begin
      cnt_s = cnt_r + CW'(1'b1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Counter and registered expiry flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      expired_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      expired_r <= (cnt_s == TMAX);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed, checksummed byte stream, writes 16-bit
// instructions from address 0 and holds the core in reset until verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INSN_W  = INSN_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INSN_W-1:0] wr_data,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  // One extra bit so COUNT=0 can represent a full 2^ADDR_W image.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1'b1) << ADDR_W;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [7:0]        hi_r, hi_s;
  logic [7:0]        sum_r, sum_s;
  logic              wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [INSN_W-1:0] wr_data_r, wr_data_s;
  logic              in_ready_r, core_rst_r, done_r, err_r;
  logic              xfer_s, active_s, expired_s;

  assign xfer_s   = in_valid && in_ready_r;
  assign active_s = (state_r == HI) || (state_r == LO) || (state_r == CSUM);

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (xfer_s || !active_s),
    .en      (active_s),
    .expired (expired_s)
  );

  // Next-state, byte assembly, checksum and address logic.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    cnt_s     = cnt_r;
    hi_s      = hi_r;
    sum_s     = sum_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_s = HI;
          cnt_s   = (in_byte == 8'd0) ? FULL_CNT : CNT_W'(in_byte);
          sum_s   = in_byte;
          addr_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      HI: begin
        if (xfer_s) begin
          hi_s    = in_byte;
          sum_s   = csum_add(sum_r, in_byte);
          state_s = LO;
        end else if (expired_s) begin
          state_s = ERR;
        end else begin
          state_s = HI;
        end
      end
      LO: begin
        if (xfer_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = addr_r;
          wr_data_s = {hi_r, in_byte};
          addr_s    = addr_r + ADDR_W'(1'b1);
          cnt_s     = cnt_r - CNT_W'(1'b1);
          sum_s     = csum_add(sum_r, in_byte);
          state_s   = (cnt_r == CNT_W'(1'b1)) ? CSUM : HI;
        end else if (expired_s) begin
          state_s = ERR;
        end else begin
          state_s = LO;
        end
      end
      CSUM: begin
        if (xfer_s) begin
          sum_s   = csum_add(sum_r, in_byte);
          state_s = (csum_add(sum_r, in_byte) == 8'd0) ? DONE : ERR;
        end else if (expired_s) begin
          state_s = ERR;
        end else begin
          state_s = CSUM;
        end
      end
      DONE, ERR: begin
        if (reload) begin
          state_s = IDLE;
          addr_s  = '0;
          cnt_s   = '0;
          sum_s   = 8'd0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      cnt_r      <= '0;
      hi_r       <= 8'd0;
      sum_r      <= 8'd0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      in_ready_r <= 1'b1;
      core_rst_r <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      cnt_r      <= cnt_s;
      hi_r       <= hi_s;
      sum_r      <= sum_s;
      wr_en_r    <= wr_en_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      in_ready_r <= (state_s != DONE) && (state_s != ERR);
      core_rst_r <= (state_s != DONE);
      done_r     <= (state_s == DONE);
      err_r      <= (state_s == ERR);
    end
  end

  assign in_ready = in_ready_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign core_rst = core_rst_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a
// negedge monitor checks every write strobe against the queue.
module tb_imem_loader;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       reload;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [15:0] wr_data;
  logic       core_rst;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_cnt = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  body[$];
  logic [23:0] mon_e;
  logic        prev_wr = 1'b0;

  imem_loader #(.ADDR_W(8), .INSN_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .reload   (reload),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt++;
        chk("wr_en_one_cycle", 32'(prev_wr), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(mon_e[23:16]));
          chk("wr_data", 32'(wr_data), 32'(mon_e[15:0]));
        end
      end
      prev_wr <= wr_en;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_stall: in_ready stuck at 0 for byte %0h", b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] count, input logic [7:0] csum);
    logic [7:0] a = 8'd0;
    send_byte(count);
    for (int i = 0; i + 1 < body.size(); i += 2) begin
      exp_q.push_back({a, body[i], body[i+1]});
      send_byte(body[i]);
      send_byte(body[i+1]);
      a = a + 8'd1;
    end
    send_byte(csum);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  initial begin
    int c0;
    int w0;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'd0; reload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good frame: 02+12+34+AB+CD = 0xC0, so CSUM = 0x40.
    body = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    w0 = wr_cnt;
    run_frame(8'h02, 8'h40);
    chk("a_done",     32'(done),     32'd1);
    chk("a_core_rst", 32'(core_rst), 32'd0);
    chk("a_err",      32'(err),      32'd0);
    chk("a_in_ready", 32'(in_ready), 32'd0);
    chk("a_wr_count", 32'(wr_cnt - w0), 32'd2);

    // Reload with a byte already valid: not taken in DONE, taken next cycle.
    in_valid = 1'b1; in_byte = 8'h02;
    pulse_reload();
    chk("reload_in_ready", 32'(in_ready), 32'd1);
    chk("reload_core_rst", 32'(core_rst), 32'd1);
    chk("reload_done",     32'(done),     32'd0);
    run_frame(8'h02, 8'h41);
    chk("b_err",      32'(err),      32'd1);
    chk("b_done",     32'(done),     32'd0);
    chk("b_core_rst", 32'(core_rst), 32'd1);
    chk("b_in_ready", 32'(in_ready), 32'd0);

    // Stall after a HI byte until the idle timer fires.
    pulse_reload();
    chk("err_clear", 32'(err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h55);
    repeat (TIMEOUT - 5) @(posedge clk);
    #1;
    chk("to_not_early", 32'(err), 32'd0);
    n = 0;
    while (!err && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_err",      32'(err),      32'd1);
    chk("to_in_ready", 32'(in_ready), 32'd0);
    chk("to_core_rst", 32'(core_rst), 32'd1);
    pulse_reload();
    chk("to_reload_err",      32'(err),      32'd0);
    chk("to_reload_in_ready", 32'(in_ready), 32'd1);

    // COUNT=0: 256 instructions {i, 255-i}; each pair sums to 0xFF, total 0 -> CSUM 0x00.
    body.delete();
    for (int i = 0; i < 256; i++) begin
      body.push_back(8'(i));
      body.push_back(8'(255 - i));
    end
    w0 = wr_cnt;
    c0 = cyc;
    run_frame(8'h00, 8'h00);
    chk("full_cycles",   32'(cyc - c0), 32'd514);
    chk("full_wr_count", 32'(wr_cnt - w0), 32'd256);
    chk("full_done",     32'(done), 32'd1);
    chk("full_err",      32'(err),  32'd0);

    // Abort mid-frame with rst, then a fresh frame: 01+BE+EF = 0xAE, CSUM 0x52.
    pulse_reload();
    exp_q.push_back({8'h00, 8'h11, 8'h22});
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_core_rst", 32'(core_rst), 32'd1);
    chk("abort_done",     32'(done),     32'd0);
    chk("abort_err",      32'(err),      32'd0);
    body = '{8'hBE, 8'hEF};
    run_frame(8'h01, 8'h52);
    chk("c_done",     32'(done),     32'd1);
    chk("c_core_rst", 32'(core_rst), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
